lock_clear: RTL and testbench
=============================

Name: lock_clear

Overview:
- Downstream of the falling-piece collision checker.
- When the game FSM reports that a piece has landed (collision=1 on a downward step), this block writes the piece's four cells into board RAM.
- It then scans the board bottom-up for full rows and collapses each full row by copying every row above it down by one.
- It reports the number of lines cleared to the score/spawn logic.

Parameters:
- BOARD_W, 10, cells per row; RAM address = y*BOARD_W + x.
- BOARD_H, 24, rows; y=0 is the top, y=BOARD_H-1 is the bottom.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to lock the current piece; ignored while busy=1
- X_anchor  input  5  piece anchor column
- Y_anchor  input  6  piece anchor row
- block  input  3  tetromino type, fed to lut
- curr_rotation  input  2  rotation, fed to lut
- colour  input  6  nonzero cell value written for this piece
- ram_Q  input  6  board RAM read data; 0 = empty
- ram_addr  output  8  board RAM address
- ram_data  output  6  board RAM write data
- ram_wren  output  1  board RAM write enable
- busy  output  1  high from the cycle after an accepted start until complete
- complete  output  1  one-cycle pulse when done
- lines_cleared  output  3  rows cleared by the last operation (0..4); held until the next complete

Behaviour:
- RAM model: synchronous, one-cycle read latency. ram_Q reflects ram_addr registered on the previous edge. A write takes effect at the edge where ram_wren=1.
- Reset values: ram_addr=0, ram_data=0, ram_wren=0, busy=0, complete=0, lines_cleared=0, FSM=IDLE.
- Piece offsets come from an instantiated lut(block, curr_rotation, coord_x[7:0], coord_y[7:0]). Cell k uses coord_x[2k+1:2k] and coord_y[2k+1:2k], k=0..3.
- IDLE:
  - On start=1, latch X_anchor, Y_anchor, block, curr_rotation and colour.
  - Clear the internal line count and go to WRITE.
  - Inputs are not sampled again until the next IDLE.
- WRITE: 4 cycles, k=0..3.
  - Drive ram_addr=(Y+cy_k)*10+X+cx_k, ram_data=colour, ram_wren=1.
  - A cell with X+cx_k>9 or Y+cy_k>23 is suppressed (ram_wren=0 that cycle) but still consumes its cycle.
  - Then go to SCAN with row r=23.
- SCAN row r:
  - Issue reads for x=0..9 on consecutive cycles and AND the term (ram_Q!=0) over the 10 returned values. This takes 11 cycles; the last compare lands one cycle after the last address.
  - If the row is full: increment the line count (saturate at 4) and go to SHIFT with s=r.
  - Else if r==0: go to DONE.
  - Else: set r=r-1 and SCAN again.
- SHIFT, row s:
  - For each x=0..9: a read cycle with ram_addr=(s-1)*10+x, then a write cycle with ram_addr=s*10+x, ram_data=ram_Q, ram_wren=1. That is 20 cycles per row.
  - Then s=s-1, repeating while s>0.
  - At s==0, write 0 to cells 0..9 (10 cycles), then return to SCAN of the same r. The row collapsed into r must be rechecked.
- DONE:
  - Drive lines_cleared=count, complete=1 and busy=0 for one cycle, then go to IDLE.
  - complete is never asserted in the same cycle as ram_wren.
- Address arithmetic is done in at least 9 bits internally, then truncated to 8 bits (max 239).
- reset mid-operation:
  - Next cycle is IDLE with ram_wren=0.
  - Partially shifted board contents are not repaired.
  - lines_cleared is zeroed.
- start while busy is dropped, not queued.
- An empty-row scan that reaches r=0 with no full rows gives lines_cleared=0.

Optional Feature:
- Macro: LOCK_CLEAR_TOTAL_EN.
- When defined:
  - Adds output total_lines [9:0].
  - Reset to 0.
  - Increases by lines_cleared at each complete; saturates at 1023.
- When undefined: the port and its counter do not exist; all other behaviour is identical.

Test Plan:
- Empty RAM. start with block/rotation whose lut offsets are (0,0),(1,0),(0,1),(1,1), X=4, Y=22, colour=6'h15 -> writes at addresses 224, 225, 234, 235 with data 0x15; full scan of all 24 rows; complete after 4+24*11+1 cycles; lines_cleared=0.
- Preload row 23 with cells 0..7 nonzero and row 22 = 0x3F in cell 5 only. Lock the O piece (offsets above) at X=8, Y=22 -> row 23 is cleared; row 22 contents move to row 23 (cell 5 = 0x3F, cells 8-9 = piece colour); row 0 is zeroed; lines_cleared=1.
- Preload rows 20..23 full except column 0; lock a vertical I piece at X=0, Y=20 -> lines_cleared=4; rows 20..23 end empty.
- Lock a piece with one cell at X+cx=10 -> that cell's write is suppressed (no ram_wren for address row*10+10); the other three are written.
- Assert reset during SHIFT -> next cycle ram_wren=0, busy=0, lines_cleared=0; a fresh start then completes normally.
- Pulse start again 3 cycles after an accepted start -> ignored: exactly one complete, and the latched X/Y are unchanged.

Source files
------------

// File: rtl/lock_clear.sv
// lock_clear: locks a landed tetromino into board RAM, then collapses full rows.
// Define LOCK_CLEAR_TOTAL_EN to add the saturating total_lines output.

module lut (
    input  logic [2:0] block,
    input  logic [1:0] curr_rotation,
    output logic [7:0] coord_x,
    output logic [7:0] coord_y
);
    // cell k offsets sit in bits [2k+1:2k]
    always_comb begin
        coord_x = 8'h44;
        coord_y = 8'h50;
        case (block)
            3'd0: begin
                coord_x = curr_rotation[0] ? 8'h00 : 8'hE4;
                coord_y = curr_rotation[0] ? 8'hE4 : 8'h00;
            end
            3'd2: begin
                coord_x = curr_rotation[1] ? 8'h91 : 8'h64;
                coord_y = curr_rotation[1] ? 8'h54 : 8'h40;
            end
            3'd3: begin
                coord_x = 8'h49;
                coord_y = 8'h50;
            end
            3'd4: begin
                coord_x = 8'h94;
                coord_y = 8'h50;
            end
            3'd5: begin
                coord_x = 8'h90;
                coord_y = 8'h54;
            end
            3'd6: begin
                coord_x = 8'h92;
                coord_y = 8'h54;
            end
            default: ;
        endcase
    end
endmodule

module lock_clear #(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [4:0] X_anchor,
    input  logic [5:0] Y_anchor,
    input  logic [2:0] block,
    input  logic [1:0] curr_rotation,
    input  logic [5:0] colour,
    input  logic [5:0] ram_Q,
    output logic [7:0] ram_addr,
    output logic [5:0] ram_data,
    output logic       ram_wren,
    output logic       busy,
    output logic       complete,
    output logic [2:0] lines_cleared
`ifdef LOCK_CLEAR_TOTAL_EN
    ,
    output logic [9:0] total_lines
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_SCAN,
        S_SHIFT,
        S_CLEAR,
        S_DONE
    } state_t;

    localparam logic [4:0] LAST_ROW = 5'(BOARD_H - 1);
    localparam logic [3:0] LAST_COL = 4'(BOARD_W - 1);
    localparam logic [3:0] SCAN_END = 4'(BOARD_W);

    state_t     state, state_d;
    logic [4:0] xa;
    logic [5:0] ya;
    logic [2:0] blk;
    logic [1:0] rot;
    logic [5:0] col;
    logic [1:0] k;
    logic [4:0] r, s;
    logic [3:0] xc;
    logic       ph, full;
    logic [2:0] cnt, lc;
    logic [7:0] cx_all, cy_all;
    logic [1:0] cx, cy;
    logic [5:0] wx;
    logic [6:0] wy;
    logic       cell_ok, nz, row_full;

    lut u_lut (
        .block        (blk),
        .curr_rotation(rot),
        .coord_x      (cx_all),
        .coord_y      (cy_all)
    );

    // wide enough that off-board pieces cannot wrap before the range check
    function automatic logic [7:0] cell_addr(
        input logic [6:0] y,
        input logic [5:0] x
    );
        logic [9:0] a;
        a = 10'(y) * 10'(BOARD_W) + 10'(x);
        return a[7:0];
    endfunction

    assign cx       = cx_all[{k, 1'b0} +: 2];
    assign cy       = cy_all[{k, 1'b0} +: 2];
    assign wx       = {1'b0, xa} + {4'b0, cx};
    assign wy       = {1'b0, ya} + {5'b0, cy};
    assign cell_ok  = (wx < 6'(BOARD_W)) && (wy < 7'(BOARD_H));
    assign nz       = (ram_Q != '0);
    assign row_full = full && nz;

    assign busy          = (state != S_IDLE) && (state != S_DONE);
    assign complete      = (state == S_DONE);
    assign lines_cleared = complete ? cnt : lc;

    always_comb begin
        state_d  = state;
        ram_addr = '0;
        ram_data = '0;
        ram_wren = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) state_d = S_WRITE;
            end
            S_WRITE: begin
                ram_addr = cell_addr(wy, wx);
                ram_data = col;
                ram_wren = cell_ok;
                if (k == 2'd3) state_d = S_SCAN;
            end
            S_SCAN: begin
                ram_addr = cell_addr({2'b0, r}, {2'b0, xc});
                if (xc == SCAN_END) begin
                    if (row_full)
                        state_d = (r == '0) ? S_CLEAR : S_SHIFT;
                    else if (r == '0)
                        state_d = S_DONE;
                end
            end
            S_SHIFT: begin
                if (ph) begin
                    ram_addr = cell_addr({2'b0, s}, {2'b0, xc});
                    ram_data = ram_Q;
                    ram_wren = 1'b1;
                    if (xc == LAST_COL && s == 5'd1) state_d = S_CLEAR;
                end else begin
                    ram_addr = cell_addr({2'b0, s - 5'd1}, {2'b0, xc});
                end
            end
            S_CLEAR: begin
                ram_addr = cell_addr(7'd0, {2'b0, xc});
                ram_wren = 1'b1;
                if (xc == LAST_COL) state_d = S_SCAN;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            xa   <= '0;
            ya   <= '0;
            blk  <= '0;
            rot  <= '0;
            col  <= '0;
            k    <= '0;
            r    <= '0;
            s    <= '0;
            xc   <= '0;
            ph   <= 1'b0;
            full <= 1'b0;
            cnt  <= '0;
            lc   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        xa  <= X_anchor;
                        ya  <= Y_anchor;
                        blk <= block;
                        rot <= curr_rotation;
                        col <= colour;
                        k   <= '0;
                        cnt <= '0;
                    end
                end
                S_WRITE: begin
                    k  <= k + 2'd1;
                    r  <= LAST_ROW;
                    xc <= '0;
                end
                S_SCAN: begin
                    if (xc == SCAN_END) begin
                        xc <= '0;
                        ph <= 1'b0;
                        if (row_full) begin
                            if (cnt != 3'd4) cnt <= cnt + 3'd1;
                            s <= r;
                        end else if (r != '0) begin
                            r <= r - 5'd1;
                        end
                    end else begin
                        // data for column xc-1 arrives while xc is addressed
                        xc   <= xc + 4'd1;
                        full <= (xc == '0) || (full && nz);
                    end
                end
                S_SHIFT: begin
                    ph <= ~ph;
                    if (ph) begin
                        if (xc == LAST_COL) begin
                            xc <= '0;
                            s  <= s - 5'd1;
                        end else begin
                            xc <= xc + 4'd1;
                        end
                    end
                end
                S_CLEAR: xc <= (xc == LAST_COL) ? '0 : xc + 4'd1;
                S_DONE:  lc <= cnt;
                default: ;
            endcase
        end
    end

`ifdef LOCK_CLEAR_TOTAL_EN
    logic [10:0] total_sum;

    assign total_sum = {1'b0, total_lines} + {8'b0, cnt};

    always_ff @(posedge clk) begin
        if (reset)
            total_lines <= '0;
        else if (complete)
            total_lines <= total_sum[10] ? 10'h3FF : total_sum[9:0];
    end
`endif

endmodule

// File: tb/tb_lock_clear.sv
// tb_lock_clear: vector table, hand sequences and randomized lock operations
// checked against a row-level board model.
module tb_lock_clear;
    logic       clk = 1'b0;
    logic       reset, start;
    logic [4:0] X_anchor;
    logic [5:0] Y_anchor;
    logic [2:0] block;
    logic [1:0] curr_rotation;
    logic [5:0] colour, ram_Q, ram_data;
    logic [7:0] ram_addr;
    logic       ram_wren, busy, complete;
    logic [2:0] lines_cleared;
`ifdef LOCK_CLEAR_TOTAL_EN
    logic [9:0] total_lines;
    int         exp_total = 0;
`endif

    always #5 clk = ~clk;

    lock_clear dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .X_anchor     (X_anchor),
        .Y_anchor     (Y_anchor),
        .block        (block),
        .curr_rotation(curr_rotation),
        .colour       (colour),
        .ram_Q        (ram_Q),
        .ram_addr     (ram_addr),
        .ram_data     (ram_data),
        .ram_wren     (ram_wren),
        .busy         (busy),
        .complete     (complete),
        .lines_cleared(lines_cleared)
`ifdef LOCK_CLEAR_TOTAL_EN
        ,
        .total_lines  (total_lines)
`endif
    );

    // board RAM: registered read, write at the enabled edge
    logic [5:0] mem [256];
    logic [5:0] img [256];
    logic       load = 1'b0;

    always @(posedge clk) begin
        if (load) mem <= img;
        else if (ram_wren) mem[ram_addr] <= ram_data;
        ram_Q <= mem[ram_addr];
    end

    int ncomp = 0;
    bit overlap = 1'b0;

    always @(posedge clk) begin
        if (complete) ncomp <= ncomp + 1;
        if (complete && ram_wren) overlap <= 1'b1;
    end

    typedef struct packed {
        int pre;
        int blk;
        int rot;
        int x;
        int y;
        int col;
        int lines;
        int nw;
    } vec_t;

    vec_t tv [5];
    int   checks = 0;
    int   errors = 0;
    int   mb [240];
    int   exp_w [$];
    int   exp_lines, exp_cyc;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // only I (block 0) and O (block 1) pieces are exercised
    task automatic piece_cell(input int blk, input int rot, input int k,
                              output int cx, output int cy);
        if (blk == 1) begin
            cx = k % 2;
            cy = k / 2;
        end else if (rot % 2 == 1) begin
            cx = 0;
            cy = k;
        end else begin
            cx = k;
            cy = 0;
        end
    endtask

    function automatic bit row_is_full(input int r);
        for (int x = 0; x < 10; x++)
            if (mb[r * 10 + x] == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_lock(input int blk, input int rot, input int x0,
                              input int y0, input int col);
        int cx, cy, x, y, r;
        exp_w = {};
        for (int k = 0; k < 4; k++) begin
            piece_cell(blk, rot, k, cx, cy);
            x = x0 + cx;
            y = y0 + cy;
            if (x < 10 && y < 24) begin
                mb[y * 10 + x] = col;
                exp_w.push_back(y * 10 + x);
            end
        end
        exp_lines = 0;
        exp_cyc = 5;
        r = 23;
        while (1) begin
            exp_cyc += 11;
            if (row_is_full(r)) begin
                if (exp_lines < 4) exp_lines++;
                exp_cyc += 20 * r + 10;
                for (int yy = r; yy > 0; yy--)
                    for (int xx = 0; xx < 10; xx++)
                        mb[yy * 10 + xx] = mb[(yy - 1) * 10 + xx];
                for (int xx = 0; xx < 10; xx++) mb[xx] = 0;
            end else if (r == 0) begin
                break;
            end else begin
                r--;
            end
        end
    endtask

    task automatic load_board();
        for (int i = 0; i < 256; i++)
            img[i] = (i < 240) ? 6'(mb[i]) : 6'd0;
        @(negedge clk);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic set_pre(input int p);
        for (int i = 0; i < 240; i++) mb[i] = 0;
        if (p == 2) begin
            for (int x = 0; x < 8; x++) mb[230 + x] = x + 1;
            mb[225] = 'h3F;
        end else if (p == 3) begin
            for (int y = 20; y < 24; y++)
                for (int x = 1; x < 10; x++) mb[y * 10 + x] = 5 + y;
        end else if (p == 4) begin
            for (int x = 0; x < 10; x++) mb[230 + x] = 9;
        end
    endtask

    task automatic do_lock(input string tag, input int blk, input int rot,
                           input int x0, input int y0, input int col,
                           input int tl, input int tnw, input int restart_at);
        int n, bad, c0, el, enw;
        int got_w [$];
        load_board();
        model_lock(blk, rot, x0, y0, col);
        el  = (tl < 0) ? exp_lines : tl;
        enw = (tnw < 0) ? exp_w.size() : tnw;
        c0  = ncomp;
        X_anchor      = 5'(x0);
        Y_anchor      = 6'(y0);
        block         = 3'(blk);
        curr_rotation = 2'(rot);
        colour        = 6'(col);
        start         = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        check({tag, " busy@1"}, int'(busy), 1);
        while (!complete && n < 6000) begin
            if (n <= 4 && ram_wren) got_w.push_back(int'(ram_addr));
            start = (n == restart_at);
            if (n == restart_at) begin
                X_anchor = 5'd0;
                Y_anchor = 6'd0;
                colour   = 6'h3F;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check({tag, " done"}, int'(complete), 1);
        check({tag, " cycles"}, n, exp_cyc);
        check({tag, " lines"}, int'(lines_cleared), el);
        check({tag, " busy@done"}, int'(busy), 0);
        check({tag, " nwrites"}, got_w.size(), enw);
        foreach (exp_w[i])
            if (i < got_w.size())
                check({tag, " waddr"}, got_w[i], exp_w[i]);
        bad = 0;
        for (int i = 0; i < 240; i++)
            if (int'(mem[i]) != mb[i]) bad++;
        check({tag, " board"}, bad, 0);
        @(negedge clk);
        check({tag, " held"}, int'(lines_cleared), el);
        check({tag, " pulse"}, int'(complete), 0);
`ifdef LOCK_CLEAR_TOTAL_EN
        exp_total = (exp_total + el > 1023) ? 1023 : exp_total + el;
        check({tag, " total"}, int'(total_lines), exp_total);
`endif
        if (restart_at > 0) repeat (300) @(negedge clk);
        check({tag, " one complete"}, ncomp - c0, 1);
    endtask

    task automatic reset_mid();
        int n;
        check("rst pre lines", int'(lines_cleared), 4);
        set_pre(4);
        load_board();
        X_anchor      = 5'd0;
        Y_anchor      = 6'd0;
        block         = 3'd1;
        curr_rotation = 2'd0;
        colour        = 6'h22;
        start         = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (n < 40) begin
            @(negedge clk);
            n++;
        end
        check("rst pre busy", int'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        check("rst wren", int'(ram_wren), 0);
        check("rst busy", int'(busy), 0);
        check("rst lines", int'(lines_cleared), 0);
        check("rst complete", int'(complete), 0);
        reset = 1'b0;
`ifdef LOCK_CLEAR_TOTAL_EN
        exp_total = 0;
`endif
        set_pre(0);
        do_lock("fresh", 1, 0, 4, 22, 'h15, 0, 4, 0);
    endtask

    initial begin
        int mode, hole;
        reset         = 1'b1;
        start         = 1'b0;
        X_anchor      = '0;
        Y_anchor      = '0;
        block         = '0;
        curr_rotation = '0;
        colour        = '0;

        tv[0] = '{0, 1, 0, 4, 22, 'h15, 0, 4};
        tv[1] = '{0, 0, 0, 7, 5, 'h11, 0, 3};
        tv[2] = '{0, 1, 2, 0, 23, 'h07, 0, 2};
        tv[3] = '{2, 1, 0, 8, 22, 'h2A, 1, 4};
        tv[4] = '{3, 0, 1, 0, 20, 'h01, 4, 4};

        repeat (3) @(negedge clk);
        check("reset addr", int'(ram_addr), 0);
        check("reset data", int'(ram_data), 0);
        check("reset wren", int'(ram_wren), 0);
        check("reset busy", int'(busy), 0);
        check("reset complete", int'(complete), 0);
        check("reset lines", int'(lines_cleared), 0);
`ifdef LOCK_CLEAR_TOTAL_EN
        check("reset total", int'(total_lines), 0);
`endif
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            set_pre(tv[i].pre);
            do_lock($sformatf("vec%0d", i), tv[i].blk, tv[i].rot,
                    tv[i].x, tv[i].y, tv[i].col,
                    tv[i].lines, tv[i].nw, 0);
            if (i == 3) begin
                check("vec3 cell235", int'(mem[235]), 'h3F);
                check("vec3 cell238", int'(mem[238]), 'h2A);
                check("vec3 cell225", int'(mem[225]), 0);
            end
        end

        reset_mid();

        set_pre(0);
        do_lock("restart", 1, 0, 4, 22, 'h15, 0, 4, 3);

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 240; i++) mb[i] = 0;
            for (int y = 18; y < 24; y++) begin
                mode = $urandom_range(0, 2);
                hole = $urandom_range(0, 9);
                for (int x = 0; x < 10; x++) begin
                    if (mode == 0 || (mode == 1 && x != hole))
                        mb[y * 10 + x] = $urandom_range(1, 63);
                    else if (mode == 2 && $urandom_range(0, 1) == 1)
                        mb[y * 10 + x] = $urandom_range(1, 63);
                end
            end
            do_lock($sformatf("rand%0d", t), $urandom_range(0, 1),
                    $urandom_range(0, 3), $urandom_range(0, 10),
                    $urandom_range(16, 23), $urandom_range(1, 63),
                    -1, -1, 0);
        end

        check("complete with wren", int'(overlap), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
